// File: rtl/gf2m_digit_serial_mul_if.sv
// Start/done handshake and operand/result bus of the digit-serial GF(2^M) multiplier.
// The controller drives the master side; the multiplier owns the slave side.
interface gf2m_digit_serial_mul_if #(
  parameter int M = 163
);
  logic         start;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic         busy;
  logic         done;
  logic [M-1:0] r_out;

  modport master (output start, a_in, b_in, input busy, done, r_out);
  modport slave  (input start, a_in, b_in, output busy, done, r_out);
endinterface

// File: rtl/gf2m_digit_serial_mul.sv
// Digit-serial MSB-first GF(2^M) multiplier r = a*b mod g(x), D bits of b per clock.
// Optional macro GF_MUL_OUT_REG_EN adds one output register stage on r_out/done.
module gf2m_digit_serial_mul #(
  parameter int           M    = 163,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = M'(8'hC9)
) (
  input logic                    clk,
  input logic                    rst_n,
  gf2m_digit_serial_mul_if.slave bus
);

  localparam int NDIG = (M + D - 1) / D;
  localparam int BW   = NDIG * D;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [M-1:0]    r_a;
  logic [M-1:0]    w_a_nxt;
  logic [BW-1:0]   r_b;
  logic [BW-1:0]   w_b_nxt;
  logic [M-1:0]    r_acc;
  logic [M-1:0]    w_acc_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [M-1:0]    r_res;
  logic [M-1:0]    w_res_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic [M-1:0]    w_chain;

  // Multiply by x and reduce modulo g(x).
  function automatic logic [M-1:0] xt(input logic [M-1:0] t);
    return {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY : {M{1'b0}});
  endfunction

  // D chained row stages over the top digit of b, MSB first.
  always_comb begin
    w_chain = r_acc;
    for (int j = D - 1; j >= 0; j--) begin
      w_chain = xt(w_chain) ^ (r_b[BW-D+j] ? r_a : {M{1'b0}});
    end
  end

  // Next-state and datapath updates for IDLE/RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = bus.a_in;
          w_b_nxt     = BW'(bus.b_in);
          w_acc_nxt   = {M{1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_acc_nxt = w_chain;
        w_b_nxt   = r_b << D;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(NDIG - 1)) begin
          w_res_nxt   = w_chain;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= {M{1'b0}};
      r_b     <= {BW{1'b0}};
      r_acc   <= {M{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_res   <= {M{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef GF_MUL_OUT_REG_EN
  logic [M-1:0] r_res_q;
  logic         r_done_q;

  // Extra output stage; busy is not delayed, so a new op may overlap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_q  <= {M{1'b0}};
      r_done_q <= 1'b0;
    end else begin
      r_res_q  <= r_res;
      r_done_q <= r_done;
    end
  end

  assign bus.r_out = r_res_q;
  assign bus.done  = r_done_q;
`else
  assign bus.r_out = r_res;
  assign bus.done  = r_done;
`endif

  assign bus.busy = (r_state == S_RUN);

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// Directed and randomized self-checking bench for gf2m_digit_serial_mul against a
// schoolbook carry-less multiply-then-reduce model of GF(2^M).
module tb_gf2m_digit_serial_mul;

  localparam int           M    = 163;
  localparam int           D    = 8;
  localparam logic [M-1:0] POLY = M'(8'hC9);
  localparam int           NDIG = (M + D - 1) / D;
`ifdef GF_MUL_OUT_REG_EN
  localparam int           LAT  = NDIG + 1;
`else
  localparam int           LAT  = NDIG;
`endif
  localparam int           NVEC = (NDIG > 40) ? 200 : 1000;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gf2m_digit_serial_mul_if #(.M(M)) bus ();

  gf2m_digit_serial_mul #(.M(M), .D(D), .POLY(POLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p;
    logic [2*M-1:0] g;
    p = '0;
    g = {{(M-1){1'b0}}, 1'b1, POLY};
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (g << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [M-1:0] t;
    t = '0;
    for (int i = 0; i < M; i += 32) t = (t << 32) | M'($urandom());
    return t;
  endfunction

  task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [M-1:0] a, input logic [M-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called one step after the accept edge; returns cycles until done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 1000) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done !== 1'b1) check("done_timeout", M'(bus.done), M'(1));
  endtask

  task automatic run_op(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                        input logic [M-1:0] exp, input bit chk_timing);
    int lat;
    int bc;
    do_start(a, b);
    wait_done(lat, bc);
    check({tag, "_r"}, bus.r_out, exp);
    if (chk_timing) begin
      check({tag, "_lat"}, M'(lat), M'(LAT));
      check({tag, "_busy"}, M'(bc), M'(NDIG));
    end
  endtask

  initial begin
    logic [M-1:0] a1, b1, a2, b2, p1;
    logic [M-1:0] ones;
    int lat;
    int bc;
    checks    = 0;
    failures  = 0;
    ones      = '1;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", M'(bus.busy), M'(0));
    check("rst_done", M'(bus.done), M'(0));
    check("rst_r", bus.r_out, '0);
    rst_n = 1'b1;

    run_op("one_x_one", M'(1), M'(1), M'(1), 1'b1);
    run_op("x162_x", M'(1) << 162, M'(2), M'(8'hC9), 1'b1);
    run_op("b_zero", M'(16'h5A5A), '0, '0, 1'b1);
    run_op("a_zero", '0, ones, '0, 1'b1);

    // start pulse mid-operation must be ignored
    a1 = rnd(); b1 = rnd(); a2 = rnd(); b2 = rnd();
    p1 = ref_mul(a1, b1);
    do_start(a1, b1);
    repeat (4) @(posedge clk);
    do_start(a2, b2);
    wait_done(lat, bc);
    check("ignore_mid_start", bus.r_out, p1);

    // start on the done cycle is accepted
    bus.start = 1'b1;
    bus.a_in  = a2;
    bus.b_in  = b2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("donecyc_done_drop", M'(bus.done), M'(0));
    check("donecyc_r_held", bus.r_out, p1);
    check("donecyc_busy", M'(bus.busy), M'(1));
    wait_done(lat, bc);
    check("donecyc_lat", M'(lat), M'(LAT));
    check("donecyc_r", bus.r_out, ref_mul(a2, b2));

    // reset in the middle of an operation aborts it
    do_start(rnd(), rnd());
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", M'(bus.busy), M'(0));
    check("abort_done", M'(bus.done), M'(0));
    check("abort_r", bus.r_out, '0);
    bc = 0;
    repeat (NDIG + 3) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) bc++;
    end
    check("abort_no_done", M'(bc), M'(0));
    @(negedge clk);
    rst_n = 1'b1;
    a1 = rnd(); b1 = rnd();
    run_op("after_abort", a1, b1, ref_mul(a1, b1), 1'b1);

    for (int v = 0; v < NVEC; v++) begin
      a1 = rnd(); b1 = rnd();
      run_op("rand", a1, b1, ref_mul(a1, b1), (v % 50) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
